// File: rtl/ohsm_sched.sv
// ohsm_sched: round-robin launcher for the shared one-hot phase sequencer.
// Define OHSM_SCHED_PRIO_EN to give requester 0 fixed top priority.
module ohsm_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [3:0]              seq_phase,
    output logic                    seq_start,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic [NREQ-1:0]         done,
    output logic                    busy,
    output logic                    err
);
    localparam int IDW = $clog2(NREQ);
    localparam logic [3:0] S1 = 4'b0001;
    localparam logic [3:0] S2 = 4'b0010;
    localparam logic [3:0] S3 = 4'b0100;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        DRAIN,
        ERR
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  ptr_d;
    logic [IDW-1:0]  win;
    logic [IDW-1:0]  id_d;
    logic [IDW-1:0]  next_id;
    logic [7:0]      cnt_q;
    logic [7:0]      cnt_d;
    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] gnt_d;
    logic [NREQ-1:0] done_d;
    logic            start_d;
    logic            busy_d;
    logic            err_d;
    logic            ph_ok;
    logic            go_err;

    assign ph_ok = (seq_phase == S1) ||
                   (seq_phase == S2) ||
                   (seq_phase == S3);

    assign next_id = (gnt_id == IDW'(NREQ - 1)) ?
                     '0 : gnt_id + IDW'(1);

    // Scan downward so the lowest offset from the pointer wins last.
    always_comb begin
        logic [IDW-1:0] k;
        k    = '0;
        cand = req;
`ifdef OHSM_SCHED_PRIO_EN
        cand[0] = 1'b0;
`endif
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = IDW'((int'(ptr_q) + i) % NREQ);
            if (cand[k]) begin
                win = k;
            end
        end
`ifdef OHSM_SCHED_PRIO_EN
        if (req[0]) begin
            win = '0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt;
        id_d    = gnt_id;
        done_d  = '0;
        start_d = seq_start;
        busy_d  = busy;
        err_d   = err;
        go_err  = !ph_ok;
        unique case (state_q)
            IDLE: begin
                if (|req && seq_phase == S1) begin
                    state_d    = LAUNCH;
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    id_d       = win;
                    start_d    = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                end
            end
            LAUNCH: begin
                if (seq_phase == S2) begin
                    state_d = RUN;
                    start_d = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    go_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RUN: begin
                if (seq_phase == S3) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (seq_phase == S1) begin
                    state_d        = IDLE;
                    gnt_d          = '0;
                    done_d[gnt_id] = 1'b1;
                    busy_d         = 1'b0;
`ifdef OHSM_SCHED_PRIO_EN
                    // A requester-0 win leaves the rotation untouched.
                    if (gnt_id != '0) begin
                        ptr_d = next_id;
                    end
`else
                    ptr_d = next_id;
`endif
                end
            end
            ERR: begin
                go_err = 1'b1;
            end
            default: begin
                go_err = 1'b1;
            end
        endcase
        if (go_err) begin
            state_d = ERR;
            gnt_d   = '0;
            done_d  = '0;
            start_d = 1'b0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            done      <= '0;
            seq_start <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt       <= gnt_d;
            gnt_id    <= id_d;
            done      <= done_d;
            seq_start <= start_d;
            busy      <= busy_d;
            err       <= err_d;
        end
    end
endmodule

// File: tb/tb_ohsm_sched.sv
// tb_ohsm_sched: self-checking bench for ohsm_sched with a
// stepping sequencer model and a transaction-level scheduler model.
module tb_ohsm_sched;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;
    localparam logic [3:0] S1 = 4'b0001;
    localparam logic [3:0] S2 = 4'b0010;
    localparam logic [3:0] S3 = 4'b0100;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic [NREQ-1:0] req   = '0;
    logic [3:0]      seq_phase;
    logic            seq_start;
    logic [NREQ-1:0] gnt;
    logic [1:0]      gnt_id;
    logic [NREQ-1:0] done;
    logic            busy;
    logic            err;

    logic [3:0] seq_q   = S1;
    logic       stuck   = 1'b0;
    logic       ovr_en  = 1'b0;
    logic [3:0] ovr_val = 4'b0000;

    int errors = 0;
    int checks = 0;

    ohsm_sched #(
        .NREQ   (NREQ),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .seq_phase(seq_phase),
        .seq_start(seq_start),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .done     (done),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!stuck) begin
            if (seq_q == S1 && seq_start) seq_q <= S2;
            else if (seq_q == S2)         seq_q <= S3;
            else if (seq_q == S3)         seq_q <= S1;
        end
    end

    assign seq_phase = ovr_en ? ovr_val : seq_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req    = '0;
        stuck  = 1'b0;
        ovr_en = 1'b0;
        reset  = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
`ifdef OHSM_SCHED_PRIO_EN
        if (r[0]) return 0;
`endif
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (p + i) % NREQ;
`ifdef OHSM_SCHED_PRIO_EN
            if (k == 0) continue;
`endif
            if (r[k]) return k;
        end
        return 0;
    endfunction

    task automatic test_reset();
        req   = 4'b1111;
        reset = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0) begin
            errors++;
            $display("FAIL reset_gnt: got %b want 0000", gnt);
        end
        checks++;
        if (done !== 4'b0 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_done_id: got %b/%0d want 0000/0", done, gnt_id);
        end
        tick();
        checks++;
        if ({seq_start, busy, err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 000", {seq_start, busy, err});
        end
        req   = '0;
        reset = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_noreq: got gnt=%b busy=%b want 0000/0", gnt, busy);
        end
    endtask

    task automatic test_single_run();
        logic [3:0] eg [6];
        logic [3:0] ed [6];
        logic       es [6];
        logic       eb [6];
        eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        ed = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        es = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        eb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        req = 4'b0001;
        for (int e = 0; e < 6; e++) begin
            tick();
            req = '0;
            checks++;
            if (gnt !== eg[e] || done !== ed[e]) begin
                errors++;
                $display("FAIL single_E%0d gnt/done: got %b/%b want %b/%b", e, gnt, done, eg[e], ed[e]);
            end
            checks++;
            if (seq_start !== es[e] || busy !== eb[e]) begin
                errors++;
                $display("FAIL single_E%0d start/busy: got %b/%b want %b/%b", e, seq_start, busy, es[e], eb[e]);
            end
        end
        checks++;
        if (gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL single_id: got %0d want 0", gnt_id);
        end
    endtask

`ifndef OHSM_SCHED_PRIO_EN
    task automatic test_fairness();
        int         gid [$];
        int         ged [$];
        int         want [5];
        logic [3:0] prev;
        want = '{0, 1, 2, 3, 0};
        prev = '0;
        do_reset();
        req = 4'b1111;
        for (int e = 0; e <= 20; e++) begin
            tick();
            if (gnt !== 4'b0 && prev === 4'b0) begin
                gid.push_back(int'(gnt_id));
                ged.push_back(e);
            end
            prev = gnt;
        end
        req = '0;
        checks++;
        if (gid.size() != 5) begin
            errors++;
            $display("FAIL fair_count: got %0d grants want 5", gid.size());
        end
        for (int i = 0; i < gid.size() && i < 5; i++) begin
            checks++;
            if (gid[i] != want[i]) begin
                errors++;
                $display("FAIL fair_order%0d: got %0d want %0d", i, gid[i], want[i]);
            end
            if (i > 0) begin
                checks++;
                if (ged[i] - ged[i-1] != 5) begin
                    errors++;
                    $display("FAIL fair_gap%0d: got %0d want 5", i, ged[i] - ged[i-1]);
                end
            end
        end
    endtask
`else
    task automatic test_prio();
        int         gid [$];
        int         want [6];
        logic [3:0] prev;
        want = '{0, 0, 0, 1, 2, 3};
        prev = '0;
        do_reset();
        req = 4'b1111;
        for (int e = 0; e < 30; e++) begin
            tick();
            if (e == 14) req = 4'b1110;
            if (gnt !== 4'b0 && prev === 4'b0) gid.push_back(int'(gnt_id));
            prev = gnt;
        end
        req = '0;
        checks++;
        if (gid.size() != 6) begin
            errors++;
            $display("FAIL prio_count: got %0d grants want 6", gid.size());
        end
        for (int i = 0; i < gid.size() && i < 6; i++) begin
            checks++;
            if (gid[i] != want[i]) begin
                errors++;
                $display("FAIL prio_order%0d: got %0d want %0d", i, gid[i], want[i]);
            end
        end
    endtask
`endif

    task automatic test_timeout();
        do_reset();
        stuck = 1'b1;
        req   = 4'b0010;
        tick();
        req = '0;
        checks++;
        if (gnt !== 4'b0010 || seq_start !== 1'b1) begin
            errors++;
            $display("FAIL to_grant: got gnt=%b start=%b want 0010/1", gnt, seq_start);
        end
        for (int e = 1; e <= TIMEOUT; e++) begin
            tick();
            checks++;
            if (err !== 1'b0 || gnt !== 4'b0010 || seq_start !== 1'b1) begin
                errors++;
                $display("FAIL to_wait%0d: got err=%b gnt=%b start=%b want 0/0010/1", e, err, gnt, seq_start);
            end
        end
        tick();
        checks++;
        if (err !== 1'b1 || gnt !== 4'b0) begin
            errors++;
            $display("FAIL to_trip: got err=%b gnt=%b want 1/0000", err, gnt);
        end
        checks++;
        if (seq_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL to_trip_ctl: got start=%b busy=%b want 0/0", seq_start, busy);
        end
        stuck = 1'b0;
        repeat (8) begin
            req = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if (err !== 1'b1 || gnt !== 4'b0 || done !== 4'b0) begin
                errors++;
                $display("FAIL to_sticky: got err=%b gnt=%b done=%b want 1/0000/0000", err, gnt, done);
            end
        end
        req   = '0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL to_clear: got err=%b want 0", err);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        req = 4'b0100;
        tick();
        req = '0;
        tick();
        tick();
        ovr_en  = 1'b1;
        ovr_val = 4'b0110;
        tick();
        ovr_en = 1'b0;
        checks++;
        if (err !== 1'b1 || seq_start !== 1'b0) begin
            errors++;
            $display("FAIL ill_run: got err=%b start=%b want 1/0", err, seq_start);
        end
        checks++;
        if (gnt !== 4'b0 || done !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ill_run_out: got gnt=%b done=%b busy=%b want 0000/0000/0", gnt, done, busy);
        end
        repeat (3) begin
            tick();
            checks++;
            if (done !== 4'b0 || err !== 1'b1) begin
                errors++;
                $display("FAIL ill_nodone: got done=%b err=%b want 0000/1", done, err);
            end
        end
        do_reset();
        req     = 4'b0001;
        ovr_en  = 1'b1;
        ovr_val = 4'b0011;
        tick();
        ovr_en = 1'b0;
        req    = '0;
        checks++;
        if (err !== 1'b1 || gnt !== 4'b0 || seq_start !== 1'b0) begin
            errors++;
            $display("FAIL ill_idle: got err=%b gnt=%b start=%b want 1/0000/0", err, gnt, seq_start);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        req = 4'b0001;
        tick();
        req = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({gnt, done, gnt_id, seq_start, busy, err} !== 13'b0) begin
            errors++;
            $display("FAIL rmid_out: got gnt=%b done=%b id=%0d s/b/e=%b want all zero", gnt, done, gnt_id, {seq_start, busy, err});
        end
        reset = 1'b1;
        tick();
        checks++;
        if (done !== 4'b0) begin
            errors++;
            $display("FAIL rmid_nodone: got %b want 0000", done);
        end
        do_reset();
        req = 4'b0010;
        tick();
        req = '0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req   = 4'b0001;
        tick();
        checks++;
        if (gnt !== 4'b0 || seq_start !== 1'b0) begin
            errors++;
            $display("FAIL rmid_wait: got gnt=%b start=%b want 0000/0", gnt, seq_start);
        end
        tick();
        req = '0;
        checks++;
        if (gnt !== 4'b0001 || seq_start !== 1'b1) begin
            errors++;
            $display("FAIL rmid_regrant: got gnt=%b start=%b want 0001/1", gnt, seq_start);
        end
    endtask

    task automatic test_random();
        int         ptr;
        int         win;
        int         age;
        bit         active;
        logic [3:0] rq;
        logic [3:0] eg;
        logic [3:0] ed;
        ptr    = 0;
        win    = 0;
        age    = 0;
        active = 1'b0;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            rq  = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
            req = rq;
            tick();
            if (active) begin
                age++;
                if (age == 4) begin
`ifdef OHSM_SCHED_PRIO_EN
                    if (win != 0) ptr = (win + 1) % NREQ;
`else
                    ptr = (win + 1) % NREQ;
`endif
                end
                if (age == 5) active = 1'b0;
            end
            if (!active && rq != 4'b0) begin
                win    = pick(rq, ptr);
                active = 1'b1;
                age    = 0;
            end
            eg = (active && age <= 3) ? 4'(1 << win) : 4'b0;
            ed = (active && age == 4) ? 4'(1 << win) : 4'b0;
            checks++;
            if (gnt !== eg) begin
                errors++;
                $display("FAIL rnd_gnt c%0d: got %b want %b", c, gnt, eg);
            end
            checks++;
            if (done !== ed) begin
                errors++;
                $display("FAIL rnd_done c%0d: got %b want %b", c, done, ed);
            end
            checks++;
            if (seq_start !== (active && age <= 1)) begin
                errors++;
                $display("FAIL rnd_start c%0d: got %b want %b", c, seq_start, active && age <= 1);
            end
            checks++;
            if (busy !== (active && age <= 3) || err !== 1'b0) begin
                errors++;
                $display("FAIL rnd_busy c%0d: got busy=%b err=%b want %b/0", c, busy, err, active && age <= 3);
            end
            checks++;
            if (gnt_id !== 2'(win)) begin
                errors++;
                $display("FAIL rnd_id c%0d: got %0d want %0d", c, gnt_id, win);
            end
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single_run();
`ifndef OHSM_SCHED_PRIO_EN
        test_fairness();
`else
        test_prio();
`endif
        test_timeout();
        test_illegal();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
